cla_nibble_sequencer: RTL and testbench
=======================================

# cla_nibble_sequencer

Multi-cycle add/subtract controller that time-multiplexes a single external 4-bit carry-lookahead slice over a WIDTH-bit operand pair, one nibble per clock, least-significant nibble first. It accepts an operation on a valid/ready handshake and walks the nibbles while holding the inter-nibble carry in a register. It returns sum, carry-out and signed overflow on a second valid/ready handshake. It sits between the arithmetic requester and the shared 4-bit slice, and is the only driver of that slice's inputs.

## Interface
- WIDTH, 16: operand width in bits. Must be a multiple of 4 and ≥ 8. NIB = WIDTH/4.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- start_valid  in  1  requester presents an operation.
- start_ready  out  1  high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = A − B, 0 = A + B.
- cin  in  1  carry-in for add; ignored when sub=1.
- res_valid  out  1  result available (DONE state).
- res_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. For sub, 1 = no borrow.
- ovf  out  1  two's-complement overflow.
- busy  out  1  high in RUN or DONE.
- slice_a  out  4  nibble of A driven to the slice.
- slice_b  out  4  nibble of effective B driven to the slice.
- slice_cin  out  1  carry into the slice.
- slice_sum  in  4  slice sum output.
- slice_pg  in  1  slice group propagate.
- slice_gg  in  1  slice group generate.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On start_valid & start_ready, capture a into opa.
  - Capture effective B into opb: b when sub=0, ~b when sub=1.
  - Load the carry register: cin when sub=0, 1 when sub=1.
  - Clear idx to 0 and go to RUN.
- RUN, each cycle:
  - Drive slice_a = opa[4*idx+3:4*idx], slice_b = opb[4*idx+3:4*idx], slice_cin = carry.
  - At the clock edge, write slice_sum into sum[4*idx+3:4*idx].
  - At the same edge, update carry ← slice_gg | (slice_pg & carry). The slice has no usable carry-out pin; the carry is always formed from PG/GG.
  - If idx = NIB−1: set cout ← new carry and ovf ← (opa[W−1] ^ opb[W−1] ^ slice_sum[3]) ^ new carry, then go to DONE. Otherwise idx ← idx+1.
- DONE:
  - res_valid = 1. sum, cout and ovf are held stable.
  - On res_ready, go to IDLE.
- Outside RUN, slice_a, slice_b and slice_cin are driven to 0.
- start_ready = (state == IDLE).
- start_valid is ignored outside IDLE. No queueing.
- sum is fully overwritten nibble by nibble. Between operations it holds the last result.
- idx width is clog2(NIB). idx never exceeds NIB−1. No wrap-around beyond the last nibble.

## Timing
- Reset (rst_n low at an edge) gives, from the next cycle:
  - state IDLE, start_ready 1, res_valid 0, busy 0
  - sum 0, cout 0, ovf 0, carry 0, idx 0
  - slice outputs 0
- Reset asserted mid-RUN or in DONE aborts the operation. No result is presented.
- Latency: acceptance edge E0 → res_valid high after edge E_NIB (NIB cycles; 4 for WIDTH=16).
- Slice path is combinational within one cycle: slice outputs → slice → slice_sum/pg/gg → registers.
- Minimum issue interval is NIB+2 cycles: NIB RUN cycles, ≥1 DONE cycle, 1 IDLE cycle. start_ready is never high in the same cycle as res_valid.
- Back-pressure: res_ready low holds DONE indefinitely with outputs unchanged.
- res_valid deasserts the cycle after the res_ready handshake edge.

## Test plan
- Add 0x00FF + 0x0001, cin=0 → sum 0x0100, cout 0, ovf 0; res_valid exactly 4 cycles after acceptance.
- Add 0xFFFF + 0x0001, cin=0 → sum 0x0000, cout 1, ovf 0. Add 0x7FFF + 0x0000, cin=1 → sum 0x8000, cout 0, ovf 1.
- Sub 0x0005 − 0x0007 → sum 0xFFFE, cout 0, ovf 0. Sub 0x8000 − 0x0001 → sum 0x7FFF, cout 1, ovf 1.
- Hold res_ready low 5 cycles in DONE, toggling start_valid with new operands → sum/cout/ovf stable, start_ready 0, no new capture; returns to IDLE one cycle after res_ready.
- Reset low during RUN at idx=2 → next cycle IDLE, res_valid 0, busy 0, slice_a/slice_b/slice_cin 0, sum 0. A new op then completes correctly.
- Back-to-back ops with start_valid held high and res_ready tied high → acceptance every 6 cycles for WIDTH=16. Slice inputs 0 in the IDLE/DONE cycles. Repeat with WIDTH=8 → latency 2, interval 4.

Source files
------------

// File: rtl/cla_nibble_sequencer.sv
// Add/subtract controller that walks a WIDTH-bit operand pair through one shared
// external 4-bit carry-lookahead slice, least-significant nibble first.
module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_sum,
  input  logic             slice_pg,
  input  logic             slice_gg
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int BW  = IW + 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } stateT;

  stateT state;
  stateT stateNext;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic             newCarry;
  logic [IW-1:0]    idx;
  logic [BW-1:0]    base;
  logic             lastNib;

  assign base     = {idx, 2'b00};
  assign lastNib  = (idx == LAST_IDX);
  // The slice has no carry-out pin, so the ripple carry is rebuilt from PG/GG.
  assign newCarry = slice_gg | (slice_pg & carry);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext   = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    slice_a     = 4'd0;
    slice_b     = 4'd0;
    slice_cin   = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        slice_a   = opa[base +: 4];
        slice_b   = opb[base +: 4];
        slice_cin = carry;
        if (lastNib) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Subtraction is A + ~B + 1, so effective B and the initial carry are fixed at capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum[base +: 4] <= slice_sum;
          carry          <= newCarry;
          if (lastNib) begin
            cout <= newCarry;
            ovf  <= (opa[WIDTH-1] ^ opb[WIDTH-1] ^ slice_sum[3]) ^ newCarry;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer: a behavioural 4-bit CLA slice per instance, an
// integer-arithmetic reference model, vector table, random ops and corner sequences.
module tb_cla_nibble_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        startValid16, startReady16, sub16, cin16, resValid16, resReady16;
  logic [15:0] a16, b16, sum16;
  logic        cout16, ovf16, busy16, sliceCin16, slicePg16, sliceGg16;
  logic [3:0]  sliceA16, sliceB16, sliceSum16;

  logic        startValid8, startReady8, sub8, cin8, resValid8, resReady8;
  logic [7:0]  a8, b8, sum8;
  logic        cout8, ovf8, busy8, sliceCin8, slicePg8, sliceGg8;
  logic [3:0]  sliceA8, sliceB8, sliceSum8;

  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] t;
    t = {1'b0, x} + {1'b0, y};
    return {t[4], &(x ^ y), 4'(x + y + {3'b000, c})};
  endfunction

  assign {sliceGg16, slicePg16, sliceSum16} = cla4(sliceA16, sliceB16, sliceCin16);
  assign {sliceGg8, slicePg8, sliceSum8}    = cla4(sliceA8, sliceB8, sliceCin8);

  cla_nibble_sequencer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start_valid(startValid16), .start_ready(startReady16),
    .a(a16), .b(b16), .sub(sub16), .cin(cin16), .res_valid(resValid16), .res_ready(resReady16),
    .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16), .slice_a(sliceA16), .slice_b(sliceB16),
    .slice_cin(sliceCin16), .slice_sum(sliceSum16), .slice_pg(slicePg16), .slice_gg(sliceGg16)
  );

  cla_nibble_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(startValid8), .start_ready(startReady8),
    .a(a8), .b(b8), .sub(sub8), .cin(cin8), .res_valid(resValid8), .res_ready(resReady8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8), .slice_a(sliceA8), .slice_b(sliceB8),
    .slice_cin(sliceCin8), .slice_sum(sliceSum8), .slice_pg(slicePg8), .slice_gg(sliceGg8)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } VecRec;

  VecRec vecs[8];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Plain signed/unsigned integer arithmetic on w-bit operands.
  task automatic refModel(input int w, input longint a, input longint b, input bit s, input bit c,
                          output longint rs, output bit co, output bit ov);
    longint m, half, sa, sb, full, sfull;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    if (s) begin
      full  = a - b;
      co    = (a >= b);
      sfull = sa - sb;
    end else begin
      full  = a + b + longint'(c);
      co    = (full >= m);
      sfull = sa + sb + longint'(c);
    end
    rs = ((full % m) + m) % m;
    ov = (sfull < -half) || (sfull >= half);
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c,
                               input logic [15:0] expSum, input logic expCout, input logic expOvf);
    int n;
    int lat;
    longint bEff, c0, mask;
    n = 0;
    while (!startReady16 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) checkOutput("startReadyTimeout", 0, 1);
    a16 = a; b16 = b; sub16 = s; cin16 = c;
    startValid16 = 1'b1;
    resReady16   = 1'b0;
    @(negedge clk);
    startValid16 = 1'b0;
    bEff = s ? longint'(~b) : longint'(b);
    c0   = s ? 1 : longint'(c);
    lat  = 0;
    while (!resValid16 && lat < 20) begin
      if (lat < 4) begin
        mask = (longint'(1) << (4 * lat)) - 1;
        checkOutput("sliceA", sliceA16, (longint'(a) >> (4 * lat)) & 15);
        checkOutput("sliceB", sliceB16, (bEff >> (4 * lat)) & 15);
        checkOutput("sliceCin", sliceCin16, (((longint'(a) & mask) + (bEff & mask) + c0) >> (4 * lat)) & 1);
      end
      @(negedge clk);
      lat++;
    end
    checkOutput("latency16", lat, 4);
    checkOutput("sum", sum16, expSum);
    checkOutput("cout", cout16, expCout);
    checkOutput("ovf", ovf16, expOvf);
    checkOutput("startReadyInDone", startReady16, 0);
    resReady16 = 1'b1;
    @(negedge clk);
    resReady16 = 1'b0;
    checkOutput("resValidDrop", resValid16, 0);
    checkOutput("startReadyBack", startReady16, 1);
  endtask

  task automatic backToBack(input int w);
    int     acc[$];
    int     dn[$];
    logic   sr, rv, sc;
    logic [3:0] sa, sb;
    longint expSum, gotSum;
    bit     co, ov;
    if (w == 16) begin
      a16 = 16'h1234; b16 = 16'h0FF0; sub16 = 1'b0; cin16 = 1'b1;
      startValid16 = 1'b1; resReady16 = 1'b1;
      refModel(16, 64'h1234, 64'h0FF0, 1'b0, 1'b1, expSum, co, ov);
    end else begin
      a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0; cin8 = 1'b0;
      startValid8 = 1'b1; resReady8 = 1'b1;
      refModel(8, 64'h7F, 64'h01, 1'b0, 1'b0, expSum, co, ov);
    end
    for (int i = 0; i < 60 && acc.size() < 4; i++) begin
      sr = (w == 16) ? startReady16 : startReady8;
      rv = (w == 16) ? resValid16 : resValid8;
      sa = (w == 16) ? sliceA16 : sliceA8;
      sb = (w == 16) ? sliceB16 : sliceB8;
      sc = (w == 16) ? sliceCin16 : sliceCin8;
      gotSum = (w == 16) ? longint'(sum16) : longint'(sum8);
      if (sr && rv) checkOutput("readyWithValid", 1, 0);
      if (sr) acc.push_back(cyc + 1);
      if (rv) begin
        dn.push_back(cyc);
        checkOutput("b2bSum", gotSum, expSum);
        checkOutput("b2bOvf", (w == 16) ? ovf16 : ovf8, ov);
      end
      if (sr || rv) checkOutput("sliceIdleZero", {sa, sb, sc}, 0);
      @(negedge clk);
    end
    startValid16 = 1'b0;
    startValid8  = 1'b0;
    checkOutput("acceptCount", acc.size(), 4);
    checkOutput("doneCountEnough", dn.size() >= 3, 1);
    for (int i = 1; i < acc.size(); i++) checkOutput("issueInterval", acc[i] - acc[i-1], w / 4 + 2);
    for (int i = 0; i < dn.size() && i < acc.size(); i++) checkOutput("b2bLatency", dn[i] - acc[i], w / 4);
    repeat (w / 4 + 3) @(negedge clk);
    resReady16 = 1'b0;
    resReady8  = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint rs;
    bit     co, ov;
    int     n;
    logic [15:0] ra, rb;
    logic   rsub, rcin;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0;
    startValid16 = 1'b0; resReady16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; cin16 = 1'b0;
    startValid8  = 1'b0; resReady8  = 1'b0; a8  = '0; b8  = '0; sub8  = 1'b0; cin8  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstStartReady", startReady16, 1);
    checkOutput("rstResValid", resValid16, 0);
    checkOutput("rstBusy", busy16, 0);
    checkOutput("rstSum", sum16, 0);
    checkOutput("rstCoutOvf", {cout16, ovf16}, 0);
    checkOutput("rstSlice", {sliceA16, sliceB16, sliceCin16}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
    end

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rsub = 1'($urandom); rcin = 1'($urandom);
      refModel(16, longint'(ra), longint'(rb), rsub, rcin, rs, co, ov);
      applyStimulus(ra, rb, rsub, rcin, 16'(rs), co, ov);
    end

    // Back-pressure in DONE: new requests must neither be accepted nor disturb the result.
    a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; cin16 = 1'b0;
    startValid16 = 1'b1;
    @(negedge clk);
    startValid16 = 1'b0;
    n = 0;
    while (!resValid16 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bpReachDone", resValid16, 1);
    for (int i = 0; i < 5; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
      startValid16 = (i % 2 == 0);
      @(negedge clk);
      checkOutput("bpSumHeld", sum16, 16'h3333);
      checkOutput("bpFlagsHeld", {cout16, ovf16}, 0);
      checkOutput("bpStartReady", startReady16, 0);
      checkOutput("bpResValid", resValid16, 1);
    end
    startValid16 = 1'b0;
    resReady16   = 1'b1;
    @(negedge clk);
    resReady16 = 1'b0;
    checkOutput("bpBackIdle", startReady16, 1);
    checkOutput("bpValidDrop", resValid16, 0);
    checkOutput("bpSumKept", sum16, 16'h3333);

    // Reset while the third nibble is on the slice aborts the operation.
    a16 = 16'hABCD; b16 = 16'h1357; sub16 = 1'b0; cin16 = 1'b0;
    startValid16 = 1'b1;
    @(negedge clk);
    startValid16 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midRunSliceA", sliceA16, 4'hB);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abortStartReady", startReady16, 1);
    checkOutput("abortResValid", resValid16, 0);
    checkOutput("abortBusy", busy16, 0);
    checkOutput("abortSlice", {sliceA16, sliceB16, sliceCin16}, 0);
    checkOutput("abortSum", sum16, 0);
    @(negedge clk);
    refModel(16, 64'h0F0F, 64'h00F1, 1'b0, 1'b0, rs, co, ov);
    applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'(rs), co, ov);

    backToBack(16);
    backToBack(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
